// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared definitions for the LC-3 memory controller: state encoding and
// default sizing.
package lc3_mem_ctrl_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/lc3_reg.sv
// WIDTH-bit load-enable register with asynchronous active-high reset.
// Used for both MAR and MDR.
module lc3_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d whenever load is asserted; clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: MAR/MDR registers plus a small handshake FSM
// that runs one memory read or write per mio_en request, with a bounded
// wait and a sticky timeout flag.
module lc3_mem_ctrl
  import lc3_mem_ctrl_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             ld_mar,
  input  logic             ld_mdr,
  input  logic             mio_en,
  input  logic             r_w,
  input  logic             gate_mdr,
  output logic [WIDTH-1:0] mdr_out,
  output logic             mdr_oe,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_re,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             r_out,
  output logic             err
);

  state_t           state;
  state_t           next_state;
  logic [7:0]       wait_cnt;
  logic             cnt_last;
  logic             start;
  logic             rd_done;
  logic             timeout_hit;
  logic             mdr_load;
  logic [WIDTH-1:0] mdr_d;
  logic [WIDTH-1:0] mar_q;
  logic [WIDTH-1:0] mdr_q;

  assign cnt_last = (wait_cnt == 8'(TIMEOUT - 1));
  assign start    = (state == IDLE) && mio_en;

  // Completing read data takes priority over a bus load of MDR.
  assign mdr_load = rd_done | ld_mdr;
  assign mdr_d    = rd_done ? mem_rdata : bus_in;

  lc3_reg #(.WIDTH(WIDTH)) u_mar (
    .clk  (clk),
    .rst  (rst),
    .load (ld_mar),
    .d    (bus_in),
    .q    (mar_q)
  );

  lc3_reg #(.WIDTH(WIDTH)) u_mdr (
    .clk  (clk),
    .rst  (rst),
    .load (mdr_load),
    .d    (mdr_d),
    .q    (mdr_q)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; mem_ready wins over the timeout on the last wait cycle.
  always_comb begin
    next_state  = state;
    rd_done     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (mio_en) begin
          next_state = r_w ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_ready) begin
          next_state = DONE;
          rd_done    = 1'b1;
        end else if (cnt_last) begin
          next_state  = DONE;
          timeout_hit = 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_ready) begin
          next_state = DONE;
        end else if (cnt_last) begin
          next_state  = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Wait counter and sticky error: both cleared when a new access starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else if (start) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else if ((state == RD_WAIT) || (state == WR_WAIT)) begin
      if (timeout_hit) begin
        err <= 1'b1;
      end else if (!mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Strobes decode directly from state so reset removes them at once.
  assign mem_re    = (state == RD_WAIT);
  assign mem_we    = (state == WR_WAIT);
  assign r_out     = (state == DONE);
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mdr_out   = mdr_q;
  // Bus drive is blocked during an access and while reset is held.
  assign mdr_oe    = gate_mdr && !rst && ((state == IDLE) || (state == DONE));

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl: stimulus pushes expected completions,
// a negedge monitor pops and checks them whenever r_out is seen.
module tb_lc3_mem_ctrl;

  localparam int W = 16;

  typedef struct {
    logic [15:0] mdr;
    logic        err;
    logic [15:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  bus_in;
  logic          ld_mar, ld_mdr, mio_en, r_w, gate_mdr;
  logic [W-1:0]  mdr_out, mem_addr, mem_wdata, mem_rdata;
  logic          mdr_oe, mem_re, mem_we, mem_ready, r_out, err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int re_cycles = 0;
  int we_cycles = 0;
  int rout_count = 0;
  int rout_cyc[$];
  exp_t sb[$];

  lc3_mem_ctrl #(.WIDTH(W), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_in    (bus_in),
    .ld_mar    (ld_mar),
    .ld_mdr    (ld_mdr),
    .mio_en    (mio_en),
    .r_w       (r_w),
    .gate_mdr  (gate_mdr),
    .mdr_out   (mdr_out),
    .mdr_oe    (mdr_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .r_out     (r_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] m, input logic e, input logic [15:0] a);
    exp_t x;
    x.mdr = m; x.err = e; x.addr = a;
    sb.push_back(x);
  endtask

  // Monitor: counts strobe cycles and scores every r_out pulse.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_re) re_cycles++;
      if (mem_we) we_cycles++;
      if (mem_re || mem_we) check("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
      if (r_out) begin
        rout_count++;
        rout_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_r_out", 32'd1, 32'd0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          check("done_mdr", {16'd0, mdr_out}, {16'd0, x.mdr});
          check("done_err", {31'd0, err}, {31'd0, x.err});
          check("done_addr", {16'd0, mem_addr}, {16'd0, x.addr});
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int re0, we0, rc0, n;
    rst = 1'b1; bus_in = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
    gate_mdr = 1'b1; mem_rdata = '0; mem_ready = 0;
    #2;
    // Reset values
    check("rst_mem_re", {31'd0, mem_re}, 0);
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_r_out", {31'd0, r_out}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_mdr_oe", {31'd0, mdr_oe}, 0);
    check("rst_mar", {16'd0, mem_addr}, 0);
    check("rst_mdr", {16'd0, mdr_out}, 0);
    step();
    rst = 1'b0; gate_mdr = 1'b0;
    step();

    // Read: MAR load coincides with access start
    re0 = re_cycles; rc0 = rout_count;
    bus_in = 16'h3000; ld_mar = 1; mio_en = 1; r_w = 0;
    push(16'hBEEF, 1'b0, 16'h3000);
    step();
    ld_mar = 0; mio_en = 0;
    check("rd_addr", {16'd0, mem_addr}, 32'h3000);
    check("rd_mem_re", {31'd0, mem_re}, 1);
    mem_ready = 1; mem_rdata = 16'hBEEF;
    step();
    mem_ready = 0;
    check("rd_r_out", {31'd0, r_out}, 1);
    step();
    check("rd_re_cycles", re_cycles - re0, 1);
    check("rd_rout_count", rout_count - rc0, 1);
    check("rd_idle_no_rout", {31'd0, r_out}, 0);

    // Write with three wait cycles
    bus_in = 16'h4001; ld_mar = 1; step(); ld_mar = 0;
    bus_in = 16'h1234; ld_mdr = 1; step(); ld_mdr = 0;
    bus_in = 16'h0000;
    check("wr_wdata_load", {16'd0, mem_wdata}, 32'h1234);
    we0 = we_cycles; rc0 = rout_count;
    mio_en = 1; r_w = 1;
    push(16'h1234, 1'b0, 16'h4001);
    step();
    mio_en = 0; r_w = 0;
    for (int i = 0; i < 3; i++) step();
    check("wr_mem_we", {31'd0, mem_we}, 1);
    check("wr_addr", {16'd0, mem_addr}, 32'h4001);
    check("wr_wdata", {16'd0, mem_wdata}, 32'h1234);
    mem_ready = 1; mem_rdata = 16'hDEAD;
    step();
    mem_ready = 0;
    step();
    check("wr_we_cycles", we_cycles - we0, 4);
    check("wr_rout_count", rout_count - rc0, 1);

    // Timeout read: 15 wait cycles, err set, MDR unchanged
    re0 = re_cycles;
    mio_en = 1; r_w = 0;
    push(16'h1234, 1'b1, 16'h4001);
    step();
    mio_en = 0;
    n = 0;
    while (!r_out && n < 40) begin
      step();
      n++;
    end
    check("to_reached_done", {31'd0, r_out}, 1);
    step();
    check("to_re_cycles", re_cycles - re0, 15);
    check("to_err_sticky", {31'd0, err}, 1);
    check("to_mdr_kept", {16'd0, mdr_out}, 32'h1234);

    // Next access clears err
    mio_en = 1; r_w = 1;
    push(16'h1234, 1'b0, 16'h4001);
    step();
    mio_en = 0; r_w = 0;
    check("err_cleared", {31'd0, err}, 0);
    mem_ready = 1;
    step();
    mem_ready = 0;
    step();

    // mem_ready on the final wait cycle wins over timeout
    re0 = re_cycles;
    mio_en = 1; r_w = 0;
    push(16'h0F0F, 1'b0, 16'h4001);
    step();
    mio_en = 0;
    for (int i = 0; i < 14; i++) step();
    mem_ready = 1; mem_rdata = 16'h0F0F;
    step();
    mem_ready = 0;
    step();
    check("edge_re_cycles", re_cycles - re0, 15);
    check("edge_err", {31'd0, err}, 0);

    // mem_ready while idle is ignored
    rc0 = rout_count;
    mem_ready = 1; mem_rdata = 16'h7777;
    step(); step();
    mem_ready = 0;
    check("idle_ready_mdr", {16'd0, mdr_out}, 32'h0F0F);
    check("idle_ready_rout", rout_count - rc0, 0);

    // Conflict: memory data beats ld_mdr; mdr_oe gated during access
    gate_mdr = 1;
    #1;
    check("oe_idle", {31'd0, mdr_oe}, 1);
    mio_en = 1; r_w = 0;
    push(16'h5555, 1'b0, 16'h4001);
    step();
    mio_en = 0;
    check("oe_in_access", {31'd0, mdr_oe}, 0);
    mem_ready = 1; mem_rdata = 16'h5555; ld_mdr = 1; bus_in = 16'hAAAA;
    step();
    mem_ready = 0; ld_mdr = 0; bus_in = 16'h0000;
    check("oe_done", {31'd0, mdr_oe}, 1);
    check("conflict_mdr", {16'd0, mdr_out}, 32'h5555);
    step();
    gate_mdr = 0;

    // Reset mid-access
    rc0 = rout_count;
    mio_en = 1; r_w = 0;
    step();
    mio_en = 0;
    check("rstmid_re_before", {31'd0, mem_re}, 1);
    #2;
    rst = 1;
    #1;
    check("rstmid_re", {31'd0, mem_re}, 0);
    check("rstmid_mdr", {16'd0, mdr_out}, 0);
    check("rstmid_mar", {16'd0, mem_addr}, 0);
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) step();
    check("rstmid_no_rout", rout_count - rc0, 0);

    // Back-to-back reads with mio_en held
    bus_in = 16'h3000; ld_mar = 1; step(); ld_mar = 0;
    rc0 = rout_count;
    mio_en = 1; r_w = 0; mem_ready = 1; mem_rdata = 16'h1111;
    push(16'h1111, 1'b0, 16'h3000);
    push(16'h2222, 1'b0, 16'h3000);
    step();
    step();
    mem_rdata = 16'h2222;
    step();
    step();
    mio_en = 0;
    step();
    mem_ready = 0;
    step(); step();
    check("b2b_rout_count", rout_count - rc0, 2);
    if (rout_cyc.size() >= 2)
      check("b2b_spacing", rout_cyc[rout_cyc.size()-1] - rout_cyc[rout_cyc.size()-2], 3);
    else
      check("b2b_pulses_seen", rout_cyc.size(), 2);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
